// File: rtl/pn_serializer.sv
// Parallel-to-serial converter for PN words: loads a word plus a bit count and
// shifts that many bits out LSB first, reloading back-to-back on the last bit.
module pn_serializer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rnd_i,
    input  logic [LEN_W-1:0]  rnd_len,
    output logic              ack,
    output logic              dat_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SER  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic              load;

    // A length of 0 means a full DATA_W frame; the modulo-2**LEN_W wrap of
    // (len - 1) yields exactly DATA_W-1 in that case.
    function automatic logic [LEN_W-1:0] last_idx(input logic [LEN_W-1:0] len);
        return len - LEN_W'(1);
    endfunction

    assign load = (state == IDLE) || (cnt == '0);

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        if (load) begin
            state_nxt = SER;
            sh_nxt    = rnd_i;
            cnt_nxt   = last_idx(rnd_len);
        end else begin
            sh_nxt  = {1'b0, sh[DATA_W-1:1]};
            cnt_nxt = cnt - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign dat_o = (state == SER) && sh[0];
    assign ack   = (state == SER) && (cnt == '0);

endmodule

// File: tb/tb_pn_serializer.sv
// Self-checking bench for pn_serializer: frame-level queue model checked every
// cycle, directed literal patterns, then randomized traffic with sporadic resets.
module tb_pn_serializer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] rnd_i = '0;
    logic [4:0]  rnd_len = '0;
    logic        ack;
    logic        dat_o;

    int n_chk  = 0;
    int n_fail = 0;

    pn_serializer #(.DATA_W(32), .LEN_W(5)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rnd_i  (rnd_i),
        .rnd_len(rnd_len),
        .ack    (ack),
        .dat_o  (dat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the bits still to be sent in the current frame. An empty queue
    // means nothing is being transmitted; a new frame is queued whenever the
    // previous one has been fully sent.
    bit q[$];
    bit model_on = 1'b0;
    bit exp_dat, exp_ack;

    always @(posedge clk_i) begin
        int len;
        if (rst_i) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (q.size() == 0) begin
                len = (rnd_len == 0) ? 32 : int'(rnd_len);
                for (int k = 0; k < len; k++) q.push_back(rnd_i[k]);
            end
        end
        exp_dat  = (q.size() > 0) ? q[0] : 1'b0;
        exp_ack  = (q.size() == 1);
        model_on = 1'b1;
    end

    always @(negedge clk_i) begin
        if (model_on) begin
            chk("model_dat_o", {31'd0, dat_o}, {31'd0, exp_dat});
            chk("model_ack",   {31'd0, ack},   {31'd0, exp_ack});
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit p8[8]   = '{1,1,0,1,0,1,0,1};
        bit p12[12] = '{1,1,0,1,0,1,0,1,1,0,0,1};
        bit prev;

        // Reset held for two edges with arbitrary inputs
        rnd_i   = $urandom;
        rnd_len = 5'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("rst_dat_o", {31'd0, dat_o}, 32'd0);
            chk("rst_ack",   {31'd0, ack},   32'd0);
        end

        // 8-bit frame 0xAB, repeated back-to-back
        rst_i   = 1'b0;
        rnd_i   = 32'h0000_00AB;
        rnd_len = 5'd8;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk_i);
            chk("ab_dat_o", {31'd0, dat_o}, {31'd0, p8[i % 8]});
            chk("ab_ack",   {31'd0, ack},   {31'd0, (i % 8) == 7});
        end

        // Mid-frame switch: the current 8-bit frame must finish unchanged
        rnd_i   = 32'h0000_09AB;
        rnd_len = 5'd12;
        for (int i = 3; i < 8; i++) begin
            @(negedge clk_i);
            chk("tail8_dat_o", {31'd0, dat_o}, {31'd0, p8[i]});
            chk("tail8_ack",   {31'd0, ack},   {31'd0, i == 7});
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_i);
            chk("f12_dat_o", {31'd0, dat_o}, {31'd0, p12[i % 12]});
            chk("f12_ack",   {31'd0, ack},   {31'd0, (i % 12) == 11});
        end

        // Full 32-bit frame via rnd_len = 0
        rnd_i   = 32'h8000_0001;
        rnd_len = 5'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_i);
            chk("f32_dat_o", {31'd0, dat_o}, {31'd0, (i == 0) || (i == 31)});
            chk("f32_ack",   {31'd0, ack},   {31'd0, i == 31});
        end

        // 1-bit frames with rnd_i[0] toggling every cycle
        rnd_len = 5'd1;
        rnd_i   = 32'd0;
        for (int i = 0; i < 10; i++) begin
            prev = rnd_i[0];
            @(negedge clk_i);
            chk("len1_dat_o", {31'd0, dat_o}, {31'd0, prev});
            chk("len1_ack",   {31'd0, ack},   32'd1);
            rnd_i = {31'd0, ~prev};
        end

        // Reset pulse at bit 4 of a 12-bit frame
        rnd_i   = 32'h0000_09AB;
        rnd_len = 5'd12;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("pre_rst_dat_o", {31'd0, dat_o}, {31'd0, p12[i]});
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_dat_o", {31'd0, dat_o}, 32'd0);
        chk("midrst_ack",   {31'd0, ack},   32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            chk("restart_dat_o", {31'd0, dat_o}, {31'd0, p12[i]});
            chk("restart_ack",   {31'd0, ack},   {31'd0, i == 11});
        end

        // Randomized traffic, checked by the model process
        for (int i = 0; i < 3000; i++) begin
            rst_i   = ($urandom_range(0, 99) == 0);
            rnd_i   = $urandom;
            rnd_len = (i % 500 < 250) ? 5'($urandom_range(0, 4)) : 5'($urandom);
            @(negedge clk_i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
